countdown_timer: RTL and testbench

Countdown timer: the mirror of the stopwatch, counting a loaded minutes:seconds value down to 0:00 instead of up from it. Sits beside the stopwatch in the clock/timer datapath and shares its binary min/sec output format, so the same display/BCD path consumes both. Driven by the system clock, with a one-cycle seconds-tick enable; a start/pause/load/clear control FSM; and a done indication at expiry.

---
 rtl/timer_pkg.sv | 21 ++
 rtl/sec_down_counter.sv | 41 ++++
 rtl/countdown_timer.sv | 133 +++++++++++++
 tb/tb_countdown_timer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Types and constants shared by the countdown timer and the stopwatch datapath.
// Both blocks present time as binary minutes and seconds of time_val_t width.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } tmr_state_e;

    localparam int TIME_W = 9;
    localparam logic [TIME_W-1:0] SEC_MAX = 9'd59;

    typedef logic [TIME_W-1:0] time_val_t;

    function automatic time_val_t clamp_val(input time_val_t v, input time_val_t lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/sec_down_counter.sv
// Mod-60 seconds register counting down, with clear, load and decrement enable.
// borrow flags a decrement taken from 0, which reloads 59 and costs one minute upstream.
module sec_down_counter
    import timer_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       load,
    input  logic [8:0] load_val,
    input  logic       dec_en,
    output logic [8:0] sec,
    output logic       borrow
);

    time_val_t sec_q;
    time_val_t sec_d;

    always_comb begin
        sec_d = sec_q;
        if (clr) begin
            sec_d = '0;
        end else if (load) begin
            sec_d = clamp_val(load_val, SEC_MAX);
        end else if (dec_en) begin
            sec_d = (sec_q == '0) ? SEC_MAX : sec_q - 9'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec_q <= '0;
        end else begin
            sec_q <= sec_d;
        end
    end

    assign sec    = sec_q;
    assign borrow = dec_en && !clr && !load && (sec_q == '0);

endmodule

// File: rtl/countdown_timer.sv
// Countdown timer: loads min:sec, counts down on sec_tick, and flags expiry at 0:00.
// Control FSM and the minute register live here; seconds come from sec_down_counter.
module countdown_timer
    import timer_pkg::*;
#(
    parameter int MAX_MIN = 99
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sec_tick,
    input  logic       tmr_reset_en,
    input  logic       tmr_load_en,
    input  logic [8:0] load_min,
    input  logic [8:0] load_sec,
    input  logic       tmr_start,
    input  logic       tmr_pause,
    output logic [8:0] tmr_min_binary,
    output logic [8:0] tmr_sec_binary,
    output logic       tmr_running,
    output logic       tmr_done,
    output logic       tmr_expire_pulse
);

    localparam time_val_t MIN_LIMIT = time_val_t'(MAX_MIN);

    tmr_state_e state_q, state_d;
    time_val_t  min_q, min_d;
    logic       running_q, running_d;
    logic       done_q, done_d;
    logic       expire_q, expire_d;

    time_val_t  sec_val;
    logic       sec_borrow;
    logic       sec_clr;
    logic       sec_load;
    logic       sec_dec;
    logic       at_zero;

    sec_down_counter u_sec (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (sec_clr),
        .load     (sec_load),
        .load_val (load_sec),
        .dec_en   (sec_dec),
        .sec      (sec_val),
        .borrow   (sec_borrow)
    );

    assign at_zero = (min_q == '0) && (sec_val == '0);

    always_comb begin
        state_d  = state_q;
        sec_clr  = 1'b0;
        sec_load = 1'b0;
        sec_dec  = 1'b0;
        expire_d = 1'b0;
        if (tmr_reset_en) begin
            state_d = IDLE;
            sec_clr = 1'b1;
        end else if (tmr_load_en && state_q != RUN) begin
            state_d  = IDLE;
            sec_load = 1'b1;
        end else begin
            // Load in RUN falls through here as if absent.
            unique case (state_q)
                IDLE: begin
                    if (!tmr_pause && tmr_start && !at_zero) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (tmr_pause) begin
                        state_d = PAUSE;
                    end else if (sec_tick) begin
                        sec_dec = !at_zero;
                        if (min_q == '0 && sec_val <= 9'd1) begin
                            state_d  = DONE;
                            expire_d = 1'b1;
                        end
                    end
                end
                PAUSE: begin
                    if (!tmr_pause && tmr_start) begin
                        state_d = RUN;
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        running_d = (state_d == RUN);
        done_d    = (state_d == DONE);
    end

    always_comb begin
        min_d = min_q;
        if (sec_clr) begin
            min_d = '0;
        end else if (sec_load) begin
            min_d = clamp_val(load_min, MIN_LIMIT);
        end else if (sec_borrow) begin
            min_d = min_q - 9'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            min_q     <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            expire_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            min_q     <= min_d;
            running_q <= running_d;
            done_q    <= done_d;
            expire_q  <= expire_d;
        end
    end

    assign tmr_min_binary   = min_q;
    assign tmr_sec_binary   = sec_val;
    assign tmr_running      = running_q;
    assign tmr_done         = done_q;
    assign tmr_expire_pulse = expire_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: directed scenarios plus random stimulus against a
// model that tracks the remaining time as a single count of seconds.
module tb_countdown_timer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sec_tick = 1'b0;
    logic       tmr_reset_en = 1'b0;
    logic       tmr_load_en = 1'b0;
    logic [8:0] load_min = '0;
    logic [8:0] load_sec = '0;
    logic       tmr_start = 1'b0;
    logic       tmr_pause = 1'b0;
    logic [8:0] tmr_min_binary;
    logic [8:0] tmr_sec_binary;
    logic       tmr_running;
    logic       tmr_done;
    logic       tmr_expire_pulse;

    int checks = 0;
    int failures = 0;

    // Model: remaining seconds as one integer, mode 0=idle 1=run 2=pause 3=done.
    int m_total = 0;
    int m_mode = 0;
    bit m_exp = 1'b0;

    countdown_timer #(.MAX_MIN(99)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .sec_tick         (sec_tick),
        .tmr_reset_en     (tmr_reset_en),
        .tmr_load_en      (tmr_load_en),
        .load_min         (load_min),
        .load_sec         (load_sec),
        .tmr_start        (tmr_start),
        .tmr_pause        (tmr_pause),
        .tmr_min_binary   (tmr_min_binary),
        .tmr_sec_binary   (tmr_sec_binary),
        .tmr_running      (tmr_running),
        .tmr_done         (tmr_done),
        .tmr_expire_pulse (tmr_expire_pulse)
    );

    always #5 clk = ~clk;

    function automatic logic [20:0] obs_vec();
        return {tmr_min_binary, tmr_sec_binary, tmr_running, tmr_done, tmr_expire_pulse};
    endfunction

    function automatic logic [20:0] model_vec();
        logic [8:0] mm;
        logic [8:0] ss;
        mm = 9'(m_total / 60);
        ss = 9'(m_total % 60);
        return {mm, ss, (m_mode == 1), (m_mode == 3), m_exp};
    endfunction

    task automatic model_reset();
        m_total = 0;
        m_mode  = 0;
        m_exp   = 1'b0;
    endtask

    task automatic model_update(input bit rst_en, input bit ld, input int lm, input int ls,
                                input bit st, input bit ps, input bit tk);
        m_exp = 1'b0;
        if (rst_en) begin
            model_reset();
        end else if (ld && m_mode != 1) begin
            m_total = ((lm > 99) ? 99 : lm) * 60 + ((ls > 59) ? 59 : ls);
            m_mode  = 0;
        end else begin
            case (m_mode)
                0: if (!ps && st && m_total != 0) m_mode = 1;
                1: begin
                    if (ps) begin
                        m_mode = 2;
                    end else if (tk) begin
                        m_total = m_total - 1;
                        if (m_total == 0) begin
                            m_mode = 3;
                            m_exp  = 1'b1;
                        end
                    end
                end
                2: if (!ps && st) m_mode = 1;
                default: ;
            endcase
        end
    endtask

    // Drives one cycle of inputs, advances the model, and leaves time at edge + 1.
    task automatic step(input bit rst_en, input bit ld, input int lm, input int ls,
                        input bit st, input bit ps, input bit tk);
        tmr_reset_en = rst_en;
        tmr_load_en  = ld;
        load_min     = 9'(lm);
        load_sec     = 9'(ls);
        tmr_start    = st;
        tmr_pause    = ps;
        sec_tick     = tk;
        model_update(rst_en, ld, lm, ls, st, ps, tk);
        @(posedge clk);
        #1;
        tmr_reset_en = 1'b0;
        tmr_load_en  = 1'b0;
        tmr_start    = 1'b0;
        tmr_pause    = 1'b0;
        sec_tick     = 1'b0;
    endtask

    task automatic tick();
        step(0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obs_vec() !== 21'd0) begin
            failures++;
            $display("FAIL reset_held: got %h want %h", obs_vec(), 21'd0);
        end
        rst_n = 1'b1;
        model_reset();
        step(0, 0, 0, 0, 1, 0, 1);
        checks++;
        if (obs_vec() !== model_vec()) begin
            failures++;
            $display("FAIL reset_idle_start: got %h want %h", obs_vec(), model_vec());
        end
    endtask

    task automatic test_countdown();
        step(0, 1, 1, 2, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs_vec() !== model_vec()) begin
                failures++;
                $display("FAIL countdown_%0d: got %h want %h", i, obs_vec(), model_vec());
            end
        end
    endtask

    task automatic test_expire();
        step(0, 1, 0, 2, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 6; i++) begin
            if (i == 4) step(0, 0, 0, 0, 1, 0, 1);
            else tick();
            checks++;
            if (obs_vec() !== model_vec()) begin
                failures++;
                $display("FAIL expire_%0d: got %h want %h", i, obs_vec(), model_vec());
            end
        end
    endtask

    task automatic test_clamp();
        step(0, 1, 0, 75, 0, 0, 0);
        checks++;
        if (obs_vec() !== model_vec()) begin
            failures++;
            $display("FAIL clamp_sec: got %h want %h", obs_vec(), model_vec());
        end
        step(0, 1, 150, 0, 0, 0, 0);
        checks++;
        if (obs_vec() !== model_vec()) begin
            failures++;
            $display("FAIL clamp_min: got %h want %h", obs_vec(), model_vec());
        end
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        checks++;
        if (obs_vec() !== model_vec()) begin
            failures++;
            $display("FAIL start_at_zero: got %h want %h", obs_vec(), model_vec());
        end
    endtask

    task automatic test_pause();
        step(0, 1, 2, 10, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 1, 1);
        checks++;
        if (obs_vec() !== model_vec()) begin
            failures++;
            $display("FAIL pause_enter: got %h want %h", obs_vec(), model_vec());
        end
        repeat (5) tick();
        checks++;
        if (obs_vec() !== model_vec()) begin
            failures++;
            $display("FAIL pause_hold: got %h want %h", obs_vec(), model_vec());
        end
        step(0, 0, 0, 0, 1, 0, 1);
        checks++;
        if (obs_vec() !== model_vec()) begin
            failures++;
            $display("FAIL pause_resume: got %h want %h", obs_vec(), model_vec());
        end
        tick();
        checks++;
        if (obs_vec() !== model_vec()) begin
            failures++;
            $display("FAIL pause_after_tick: got %h want %h", obs_vec(), model_vec());
        end
    endtask

    task automatic test_load_in_run();
        step(0, 1, 3, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        step(0, 1, 5, 0, 0, 0, 0);
        checks++;
        if (obs_vec() !== model_vec()) begin
            failures++;
            $display("FAIL run_load_ignored: got %h want %h", obs_vec(), model_vec());
        end
        tick();
        checks++;
        if (obs_vec() !== model_vec()) begin
            failures++;
            $display("FAIL run_borrow: got %h want %h", obs_vec(), model_vec());
        end
        step(1, 1, 5, 0, 0, 0, 0);
        checks++;
        if (obs_vec() !== model_vec()) begin
            failures++;
            $display("FAIL reset_over_load: got %h want %h", obs_vec(), model_vec());
        end
    endtask

    task automatic test_async_reset();
        step(0, 1, 4, 30, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (obs_vec() !== 21'd0) begin
            failures++;
            $display("FAIL async_reset_now: got %h want %h", obs_vec(), 21'd0);
        end
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (obs_vec() !== model_vec()) begin
            failures++;
            $display("FAIL async_reset_after: got %h want %h", obs_vec(), model_vec());
        end
    endtask

    task automatic test_random();
        bit rs, ld, st, ps, tk;
        int lm, ls;
        for (int i = 0; i < 600; i++) begin
            rs = ($urandom_range(0, 99) < 2);
            ld = ($urandom_range(0, 99) < 6);
            st = ($urandom_range(0, 99) < 15);
            ps = ($urandom_range(0, 99) < 6);
            tk = ($urandom_range(0, 99) < 60);
            lm = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 300)) : int'($urandom_range(0, 1));
            ls = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 120)) : int'($urandom_range(0, 5));
            step(rs, ld, lm, ls, st, ps, tk);
            checks++;
            if (obs_vec() !== model_vec()) begin
                failures++;
                $display("FAIL random_%0d: got %h want %h", i, obs_vec(), model_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_expire();
        test_clamp();
        test_pause();
        test_load_in_run();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
